// File: rtl/pe_array_ctrl.sv
// Job sequencer for the weight-stationary systolic PE array: weight load, skewed activation stream, drain, done.
// Optional weight reuse (skip LOAD when a tile is already resident) is enabled by defining PE_CTRL_WREUSE_EN.
module pe_array_ctrl #(
  parameter int ROWS  = 13,
  parameter int COLS  = 13,
  parameter int VEC_W = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [VEC_W-1:0]                     num_vec,
`ifdef PE_CTRL_WREUSE_EN
  input  logic                                 reuse_w,
`endif
  output logic                                 busy,
  output logic                                 done,
  output logic                                 w_rd_en,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] w_rd_addr,
  output logic                                 w_en,
  output logic                                 w_compute,
  output logic                                 act_rd_en,
  output logic [VEC_W-1:0]                     act_rd_idx,
  output logic [ROWS-1:0]                      row_valid,
  output logic                                 sum_valid,
  output logic [VEC_W-1:0]                     sum_idx
);

  localparam int LAT = ROWS + COLS;
  localparam int AW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LCW = $clog2(ROWS + 1);
  localparam int DCW = $clog2(LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LCW-1:0]   r_lcnt;
  logic [VEC_W-1:0] r_vcnt;
  logic [VEC_W-1:0] r_nvec;
  logic [DCW-1:0]   r_dcnt;
  logic [ROWS-1:0]  r_rv;
  logic [LAT-1:0]   r_sv;
  logic [VEC_W-1:0] r_sidx [LAT];

  logic w_ld_last;
  logic w_vec_last;
  logic w_drn_last;
  logic w_skip_load;

  assign w_ld_last  = (r_lcnt == LCW'(ROWS));
  assign w_vec_last = (r_vcnt == r_nvec - VEC_W'(1));
  assign w_drn_last = (r_dcnt == DCW'(LAT - 1));

`ifdef PE_CTRL_WREUSE_EN
  logic r_wloaded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wloaded <= 1'b0;
    end else if (r_state == S_LOAD && w_ld_last) begin
      r_wloaded <= 1'b1;
    end
  end

  assign w_skip_load = reuse_w & r_wloaded;
`else
  assign w_skip_load = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    w_rd_en     = 1'b0;
    w_rd_addr   = '0;
    w_en        = 1'b0;
    w_compute   = 1'b0;
    act_rd_en   = 1'b0;
    act_rd_idx  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_skip_load) begin
            w_state_nxt = (num_vec == '0) ? S_DONE : S_COMPUTE;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // Address runs ROWS-1 down to 0; the shift enable trails the read by the buffer latency.
        w_rd_en = !w_ld_last;
        if (!w_ld_last) begin
          w_rd_addr = AW'(ROWS - 1 - int'(r_lcnt));
        end
        w_en = (r_lcnt != '0);
        if (w_ld_last) begin
          w_state_nxt = (r_nvec == '0) ? S_DONE : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        w_compute  = 1'b1;
        act_rd_en  = 1'b1;
        act_rd_idx = r_vcnt;
        if (w_vec_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_compute = 1'b1;
        if (w_drn_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lcnt <= '0;
      r_vcnt <= '0;
      r_dcnt <= '0;
      r_nvec <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_nvec <= num_vec;
      end
      if (r_state == S_LOAD && !w_ld_last) begin
        r_lcnt <= r_lcnt + LCW'(1);
      end else begin
        r_lcnt <= '0;
      end
      if (r_state == S_COMPUTE && !w_vec_last) begin
        r_vcnt <= r_vcnt + VEC_W'(1);
      end else begin
        r_vcnt <= '0;
      end
      if (r_state == S_DRAIN && !w_drn_last) begin
        r_dcnt <= r_dcnt + DCW'(1);
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  // Row skew and result pipes: stage k holds the read strobe delayed by k+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rv <= '0;
      r_sv <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        r_sidx[k] <= '0;
      end
    end else begin
      r_rv[0]   <= act_rd_en;
      r_sv[0]   <= act_rd_en;
      r_sidx[0] <= act_rd_en ? r_vcnt : '0;
      for (int unsigned k = 1; k < ROWS; k++) begin
        r_rv[k] <= r_rv[k-1];
      end
      for (int unsigned k = 1; k < LAT; k++) begin
        r_sv[k]   <= r_sv[k-1];
        r_sidx[k] <= r_sidx[k-1];
      end
    end
  end

  assign row_valid = r_rv;
  assign sum_valid = r_sv[LAT-1];
  assign sum_idx   = r_sidx[LAT-1];

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl (ROWS=4, COLS=4, VEC_W=8); exercises weight reuse when PE_CTRL_WREUSE_EN is defined.
module tb_pe_array_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int VEC_W = 8;
  localparam int LAT   = ROWS + COLS;
  localparam int NC    = 8192;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [VEC_W-1:0] num_vec;
  logic             reuse_w;
  logic             busy, done, w_rd_en, w_en, w_compute, act_rd_en, sum_valid;
  logic [1:0]       w_rd_addr;
  logic [VEC_W-1:0] act_rd_idx, sum_idx;
  logic [ROWS-1:0]  row_valid;

  pe_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vec    (num_vec),
`ifdef PE_CTRL_WREUSE_EN
    .reuse_w    (reuse_w),
`endif
    .busy       (busy),
    .done       (done),
    .w_rd_en    (w_rd_en),
    .w_rd_addr  (w_rd_addr),
    .w_en       (w_en),
    .w_compute  (w_compute),
    .act_rd_en  (act_rd_en),
    .act_rd_idx (act_rd_idx),
    .row_valid  (row_valid),
    .sum_valid  (sum_valid),
    .sum_idx    (sum_idx)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;
  int  idle_from = 0;
  int  last_k = 0;
  bit  mon_on = 1'b0;
  bit  wloaded = 1'b0;
  // Event queues keyed cycle*256+value: 0 w_rd, 1 w_en, 2 act_rd, 3 sum, 4 done.
  longint q [5][$];
  bit  e_busy [NC];
  bit  e_wc   [NC];
  bit  e_act  [NC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic ev(input int k, input string tag, input logic fired, input int val);
    longint key;
    key = longint'(cyc) * 256 + val;
    while (q[k].size() > 0 && q[k][0] / 256 < cyc) begin
      chk({tag, "_missing"}, 64'hFFFF_FFFF_FFFF_FFFF, q[k].pop_front());
    end
    if (fired) begin
      if (q[k].size() > 0 && q[k][0] / 256 == cyc) begin
        chk(tag, key, q[k].pop_front());
      end else begin
        chk({tag, "_unexpected"}, key, 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mon_on && cyc < NC) begin
      logic [ROWS-1:0] erv;
      ev(0, "w_rd", w_rd_en, int'(w_rd_addr));
      ev(1, "w_en", w_en, 0);
      ev(2, "act_rd", act_rd_en, int'(act_rd_idx));
      ev(3, "sum", sum_valid, int'(sum_idx));
      ev(4, "done", done, 0);
      chk("busy", busy, e_busy[cyc]);
      chk("w_compute", w_compute, e_wc[cyc]);
      for (int r = 0; r < ROWS; r++) begin
        erv[r] = (cyc - 1 - r >= 0) ? e_act[cyc-1-r] : 1'b0;
      end
      chk("row_valid", row_valid, erv);
      chk("exclusive", {w_en & act_rd_en, w_en & w_compute}, 0);
    end
  end

  function automatic logic [63:0] all_outs();
    return {35'd0, busy, done, w_rd_en, w_rd_addr, w_en, w_compute, act_rd_en,
            act_rd_idx, row_valid, sum_valid, sum_idx};
  endfunction

  // Called at a negedge; waits for the model's IDLE cycle, raises start and pushes the job's expectations.
  task automatic run_job(input int n, input bit reuse, input bit hold);
    int k, l, dn;
    while (cyc < idle_from) @(negedge clk);
    k       = cyc;
    last_k  = k;
    start   = 1'b1;
    num_vec = VEC_W'(n);
    reuse_w = reuse;
    l = (reuse && wloaded) ? 0 : ROWS + 1;
    if (l != 0) begin
      wloaded = 1'b1;
      for (int j = 0; j < ROWS; j++) begin
        q[0].push_back(longint'(k + 1 + j) * 256 + (ROWS - 1 - j));
        q[1].push_back(longint'(k + 2 + j) * 256);
      end
    end
    for (int i = 0; i < n; i++) begin
      q[2].push_back(longint'(k + 1 + l + i) * 256 + i);
      q[3].push_back(longint'(k + 1 + l + LAT + i) * 256 + i);
      e_act[k + 1 + l + i] = 1'b1;
    end
    dn = (n > 0) ? k + 1 + l + LAT + n : k + 1 + l;
    q[4].push_back(longint'(dn) * 256);
    for (int c = k + 1; c <= dn; c++) e_busy[c] = 1'b1;
    if (n > 0) for (int c = k + 1 + l; c < dn; c++) e_wc[c] = 1'b1;
    idle_from = dn + 1;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Called at a negedge; asserts reset between edges and checks outputs clear before the next edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk("rst_outputs", all_outs(), 0);
    for (int k = 0; k < 5; k++) q[k].delete();
    for (int c = 0; c < NC; c++) begin
      e_busy[c] = 1'b0;
      e_wc[c]   = 1'b0;
      e_act[c]  = 1'b0;
    end
    wloaded = 1'b0;
    start   = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    idle_from = cyc;
    @(negedge clk);
  endtask

  initial begin
    #(10 * 9000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    num_vec = '0;
    reuse_w = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_initial", all_outs(), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    idle_from = cyc;
    mon_on    = 1'b1;
    @(negedge clk);

    run_job(5, 1'b0, 1'b0);
    while (cyc < last_k + 8) @(negedge clk);
    do_reset();
    run_job(4, 1'b0, 1'b0);

    run_job(3, 1'b0, 1'b0);
    run_job(0, 1'b0, 1'b0);

    run_job(2, 1'b0, 1'b1);
    run_job(2, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;

    run_job(1, 1'b0, 1'b0);
    run_job(255, 1'b0, 1'b0);
    repeat (4) run_job(int'($urandom_range(1, 12)), 1'b0, 1'b0);

`ifdef PE_CTRL_WREUSE_EN
    run_job(2, 1'b0, 1'b0);
    run_job(2, 1'b1, 1'b0);
    run_job(0, 1'b1, 1'b0);
    while (cyc < idle_from) @(negedge clk);
    do_reset();
    run_job(1, 1'b1, 1'b0);
`endif

    while (cyc < idle_from + 3) @(negedge clk);
    chk("queues_drained", q[0].size() + q[1].size() + q[2].size() + q[3].size() + q[4].size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
